// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU/MDU.
//   - 4-bit ALUOp encodings (NOP..MFLO)
//   - FSM state encoding for the issue/iterate/fix sequencer
//   - small opcode classification helper
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOR  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_MULT = 4'hC;
  localparam logic [3:0] OP_DIV  = 4'hD;
  localparam logic [3:0] OP_MFHI = 4'hE;
  localparam logic [3:0] OP_MFLO = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Multi-cycle ops go through ITER/FIX; everything else completes in IDLE.
  function automatic logic is_mdu(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide datapath, one bit per step.
//   clk, rst      : clock, async active-low reset
//   start         : load operand magnitudes and clear the counter
//   is_div, sign  : operation select at start (divide / signed)
//   step          : perform one iteration
//   src1, src2    : operands (sampled on start)
//   last          : current step is the final iteration
//   res_hi/res_lo : sign-corrected result, valid once all steps are done
module mdu_core #(
  parameter int bit_size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_div,
  input  logic                sign,
  input  logic                step,
  input  logic [bit_size-1:0] src1,
  input  logic [bit_size-1:0] src2,
  output logic                last,
  output logic [bit_size-1:0] res_hi,
  output logic [bit_size-1:0] res_lo
);

  localparam int N  = bit_size;
  localparam int CW = $clog2(N);

  // m:   multiplicand (MULT) or divisor (DIV) magnitude
  // acc: {partial product, multiplier} for MULT, {remainder, quotient} for DIV
  logic [N-1:0]   m;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           div_q, neg_a, neg_b, dz;

  logic           a_neg, b_neg;
  logic [N-1:0]   a_mag, b_mag;
  logic [N:0]     mul_sum, trial;
  logic [2*N-1:0] mul_nxt, div_nxt, prod;
  logic [N-1:0]   q, r;

  assign a_neg = sign & src1[N-1];
  assign b_neg = sign & src2[N-1];
  assign a_mag = a_neg ? -src1 : src1;
  assign b_mag = b_neg ? -src2 : src2;

  // Shift-add: add multiplicand into the upper half when the multiplier LSB is set,
  // then shift the whole thing right, carry included.
  assign mul_sum = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? m : '0)};
  assign mul_nxt = {mul_sum, acc[N-1:1]};

  // Restoring divide: trial-subtract divisor from {rem, next dividend bit}.
  // A negative trial (top bit set) means keep the shifted remainder, quotient bit 0.
  assign trial   = acc[2*N-1:N-1] - {1'b0, m};
  assign div_nxt = trial[N] ? {acc[2*N-2:0], 1'b0} : {trial[N-1:0], acc[N-2:0], 1'b1};

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m     <= '0;
      acc   <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      dz    <= 1'b0;
    end else if (start) begin
      m     <= is_div ? b_mag : a_mag;
      acc   <= {{N{1'b0}}, (is_div ? a_mag : b_mag)};
      cnt   <= '0;
      div_q <= is_div;
      neg_a <= a_neg;
      neg_b <= b_neg;
      dz    <= is_div && (src2 == '0);
    end else if (step) begin
      acc <= div_q ? div_nxt : mul_nxt;
      cnt <= cnt + 1'b1;
    end
  end

  // Sign correction. With a zero divisor the remainder already holds |src1|,
  // so re-applying the dividend sign reproduces src1 exactly.
  assign prod = (neg_a ^ neg_b) ? -acc : acc;
  assign q    = acc[N-1:0];
  assign r    = acc[2*N-1:N];

  always_comb begin
    res_hi = prod[2*N-1:N];
    res_lo = prod[N-1:0];
    if (div_q) begin
      res_hi = neg_a ? -r : r;
      res_lo = dz ? '1 : ((neg_a ^ neg_b) ? -q : q);
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with iterative multiply/divide and HI/LO registers.
//   clk, rst          : clock, async active-low reset
//   in_valid/in_ready : issue handshake; ready only in IDLE
//   ALUOp, sign       : opcode and signed-variant select
//   src1, src2, shamt : operands and shift amount
//   out_valid         : one-cycle strobe qualifying ALU_result/Zero
//   ALU_result, Zero  : registered result and branch condition
//   hi, lo            : HI/LO registers (updated only when MULT/DIV finish)
//   busy              : MULT/DIV in progress
module alu_mdu
  import alu_pkg::*;
#(
  parameter int bit_size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          ALUOp,
  input  logic                sign,
  input  logic [bit_size-1:0] src1,
  input  logic [bit_size-1:0] src2,
  input  logic [4:0]          shamt,
  output logic                out_valid,
  output logic [bit_size-1:0] ALU_result,
  output logic                Zero,
  output logic [bit_size-1:0] hi,
  output logic [bit_size-1:0] lo,
  output logic                busy
);

  localparam int N = bit_size;
  localparam int unsigned NU = bit_size;

  state_t       state, nstate;
  logic         accept, mdu_op, start, last;
  logic [N-1:0] core_hi, core_lo;
  logic [N-1:0] alu_res, shl, shr, sha;
  logic         alu_z, sh_big;

  assign accept = in_valid & in_ready;
  assign mdu_op = is_mdu(ALUOp);
  assign start  = accept & mdu_op;

  mdu_core #(.bit_size(N)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div (ALUOp == OP_DIV),
    .sign   (sign),
    .step   (state == ST_ITER),
    .src1   (src1),
    .src2   (src2),
    .last   (last),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (start) nstate = ST_ITER;
      ST_ITER: if (last)  nstate = ST_FIX;
      ST_FIX:             nstate = ST_IDLE;
      default:            nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state != ST_IDLE);
  end

  // Explicit saturation keeps wide shamt well defined for narrow datapaths.
  assign sh_big = 32'(shamt) >= NU;
  assign shl    = sh_big ? '0 : (src2 << shamt);
  assign shr    = sh_big ? '0 : (src2 >> shamt);
  assign sha    = sh_big ? {N{src2[N-1]}} : N'($signed(src2) >>> shamt);

  always_comb begin
    alu_res = '0;
    alu_z   = 1'b0;
    case (ALUOp)
      OP_ADD:  alu_res = src1 + src2;
      OP_SUB:  alu_res = src1 - src2;
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_XOR:  alu_res = src1 ^ src2;
      OP_NOR:  alu_res = ~(src1 | src2);
      OP_SLT:  alu_res[0] = sign ? ($signed(src1) < $signed(src2)) : (src1 < src2);
      OP_SLL:  alu_res = shl;
      OP_SRL:  alu_res = sign ? sha : shr;
      OP_BEQ:  alu_z = (src1 == src2);
      OP_BNE:  alu_z = (src1 != src2);
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      ALU_result <= '0;
      Zero       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == ST_FIX) begin
        out_valid  <= 1'b1;
        hi         <= core_hi;
        lo         <= core_lo;
        ALU_result <= core_lo;
        Zero       <= 1'b0;
      end else if (accept && !mdu_op) begin
        out_valid  <= 1'b1;
        ALU_result <= alu_res;
        Zero       <= alu_z;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int N = 32;

  logic         clk, rst, in_valid, in_ready, sign, out_valid, Zero, busy;
  logic [3:0]   ALUOp;
  logic [N-1:0] src1, src2, ALU_result, hi, lo;
  logic [4:0]   shamt;

  int errors = 0;
  int checks = 0;

  alu_mdu #(.bit_size(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .sign(sign), .src1(src1), .src2(src2), .shamt(shamt),
    .out_valid(out_valid), .ALU_result(ALU_result), .Zero(Zero),
    .hi(hi), .lo(lo), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op for exactly one edge; returns at #1 after that edge.
  task automatic issue(input logic [3:0] op, input logic sg, input logic [N-1:0] a, b,
                       input logic [4:0] sh);
    @(negedge clk);
    ALUOp = op; sign = sg; src1 = a; src2 = b; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Issue a MULT/DIV and count edges until out_valid (-1 if it never comes).
  task automatic run_mdu(input logic [3:0] op, input logic sg, input logic [N-1:0] a, b,
                         output int lat);
    issue(op, sg, a, b, 5'd0);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; ALUOp = OP_NOP; sign = 1'b0;
    src1 = '0; src2 = '0; shamt = '0;
    repeat (2) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (ALU_result !== '0) begin errors++; $display("FAIL reset_result: got %h exp 0", ALU_result); end
    checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b exp 0", Zero); end
    checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL reset_hilo: got %h/%h exp 0/0", hi, lo); end
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready: got ready=%b busy=%b exp 1/0", in_ready, busy); end
  endtask

  task automatic test_basic();
    issue(OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b exp 1", out_valid); end
    checks++; if (ALU_result !== 32'h0) begin errors++; $display("FAIL add_wrap: got %h exp 0", ALU_result); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_strobe_one_cycle: got %b exp 0", out_valid); end
    issue(OP_BEQ, 1'b0, 32'd5, 32'd5, 5'd0);
    checks++; if (Zero !== 1'b1 || ALU_result !== 32'h0) begin errors++; $display("FAIL beq_equal: got Zero=%b res=%h exp 1/0", Zero, ALU_result); end
    issue(OP_BEQ, 1'b0, 32'd5, 32'd6, 5'd0);
    checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL beq_differ: got %b exp 0", Zero); end
    issue(OP_SLT, 1'b1, 32'hFFFF_FFFF, 32'h1, 5'd0);
    checks++; if (ALU_result !== 32'h1) begin errors++; $display("FAIL slt_signed: got %h exp 1", ALU_result); end
    issue(OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd0);
    checks++; if (ALU_result !== 32'h0) begin errors++; $display("FAIL slt_unsigned: got %h exp 0", ALU_result); end
    issue(OP_SRL, 1'b0, 32'h0, 32'h8000_0000, 5'd4);
    checks++; if (ALU_result !== 32'h0800_0000) begin errors++; $display("FAIL srl_logical: got %h exp 08000000", ALU_result); end
    issue(OP_SRL, 1'b1, 32'h0, 32'h8000_0000, 5'd4);
    checks++; if (ALU_result !== 32'hF800_0000) begin errors++; $display("FAIL srl_arith: got %h exp f8000000", ALU_result); end
    issue(OP_ADD, 1'b0, 32'h1234, 32'h1, 5'd0);
    checks++; if (ALU_result !== 32'h1235) begin errors++; $display("FAIL add_plain: got %h exp 1235", ALU_result); end
    issue(OP_MFHI, 1'b0, 32'h0, 32'h0, 5'd0);
    checks++; if (ALU_result !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL mfhi_reset: got %h v=%b exp 0 v=1", ALU_result, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   op [9] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_BNE, OP_NOP, OP_SUB};
    logic         sg [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [N-1:0] a  [9] = '{32'hA5A5_A5A5, 32'h1234_0000, 32'hFFFF_0000, 32'h0, 32'h0, 32'h0, 32'd5, 32'h7, 32'h0};
    logic [N-1:0] b  [9] = '{32'h0F0F_0F0F, 32'h0000_5678, 32'h0F0F_0F0F, 32'h0, 32'h1, 32'h8000_0000, 32'd6, 32'h9, 32'h1};
    logic [4:0]   sh [9] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0};
    logic [N-1:0] er [9] = '{32'h0505_0505, 32'h1234_5678, 32'hF0F0_0F0F, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF};
    logic         ez [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      ALUOp = op[i]; sign = sg[i]; src1 = a[i]; src2 = b[i]; shamt = sh[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || ALU_result !== er[i] || Zero !== ez[i]) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b res=%h z=%b exp v=1 res=%h z=%b", i, out_valid, ALU_result, Zero, er[i], ez[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || ALU_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_hold: got v=%b res=%h exp v=0 res=ffffffff", out_valid, ALU_result); end
  endtask

  task automatic test_mult();
    int lat;
    issue(OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5, 5'd0);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mult_busy: got ready=%b busy=%b v=%b exp 0/1/0", in_ready, busy, out_valid); end
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      // An ADD offered while busy must be dropped, not queued.
      if (i == 5) begin ALUOp = OP_ADD; sign = 1'b0; src1 = 32'h1; src2 = 32'h1; in_valid = 1'b1; end
      if (i == 7) in_valid = 1'b0;
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    in_valid = 1'b0;
    checks++; if (lat != 33) begin errors++; $display("FAIL mult_latency: got %0d exp 33", lat); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_hilo: got %h/%h exp ffffffff/fffffff1", hi, lo); end
    checks++; if (ALU_result !== 32'hFFFF_FFF1 || Zero !== 1'b0) begin errors++; $display("FAIL mult_result: got %h z=%b exp fffffff1 z=0", ALU_result, Zero); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mult_ready_at_fix: got %b exp 1", in_ready); end
    // MFHI presented in the completion cycle.
    ALUOp = OP_MFHI; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || ALU_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mfhi_after_mult: got v=%b res=%h exp v=1 res=ffffffff", out_valid, ALU_result); end
    ALUOp = OP_MFLO;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (ALU_result !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mflo_after_mult: got %h exp fffffff1", ALU_result); end
    run_mdu(OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if (lat != 33 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin errors++; $display("FAIL mult_unsigned_max: got lat=%0d %h/%h exp 33 fffffffe/00000001", lat, hi, lo); end
  endtask

  task automatic test_div();
    logic         sg [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [N-1:0] a  [5] = '{32'd100, 32'hFFFF_FFF9, 32'd9, 32'h8000_0000, 32'hFFFF_FFF7};
    logic [N-1:0] b  [5] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [N-1:0] eh [5] = '{32'd2, 32'hFFFF_FFFF, 32'd9, 32'h0, 32'hFFFF_FFF7};
    logic [N-1:0] el [5] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_mdu(OP_DIV, sg[i], a[i], b[i], lat);
      checks++;
      if (lat != 33 || hi !== eh[i] || lo !== el[i] || ALU_result !== el[i]) begin
        errors++;
        $display("FAIL div_%0d: got lat=%0d hi=%h lo=%h res=%h exp 33 hi=%h lo=%h", i, lat, hi, lo, ALU_result, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    int early;
    issue(OP_DIV, 1'b0, 32'd1000, 32'd3, 5'd0);
    repeat (10) @(posedge clk);
    #1; rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || hi !== '0 || lo !== '0 || ALU_result !== '0) begin errors++; $display("FAIL midreset_outputs: got v=%b hi=%h lo=%h res=%h exp all 0", out_valid, hi, lo, ALU_result); end
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b exp 1", in_ready); end
    early = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL midreset_no_strobe: got %0d strobes exp 0", early); end
    issue(OP_ADD, 1'b0, 32'd2, 32'd3, 5'd0);
    checks++; if (out_valid !== 1'b1 || ALU_result !== 32'd5) begin errors++; $display("FAIL midreset_next_op: got v=%b res=%h exp v=1 res=5", out_valid, ALU_result); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_mult();
    test_div();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
